// File: rtl/kws_report_pkg.sv
// ============================================================================
// Module      : kws_report_pkg
// Description : Shared frame constants, state encodings and frame-byte helper
//               for the KWS result reporter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kws_report_pkg;

    localparam logic [7:0] FRAME_SYNC  = 8'hA5;
    localparam int         FRAME_BYTES = 4;
    localparam logic [7:0] NO_KEYWORD  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_DECIDE = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_STOP   = 3'd5,
        ST_DONE   = 3'd6
    } rpt_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_phase_t;

    // Byte 3 is the XOR checksum of the first three bytes.
    function automatic logic [7:0] frame_byte(input logic [1:0] sel,
                                              input logic [7:0] kw,
                                              input logic [7:0] pop);
        logic [7:0] b;
        case (sel)
            2'd0:    b = FRAME_SYNC;
            2'd1:    b = kw;
            2'd2:    b = pop;
            default: b = FRAME_SYNC ^ kw ^ pop;
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kws_result_reporter_if.sv
// ============================================================================
// Module      : kws_result_if
// Description : Detection vector plus one-cycle valid from the KWS core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface kws_result_if #(
    parameter int NUM_KEYWORDS = 10
);
    logic [NUM_KEYWORDS-1:0] kws_result;
    logic                    kws_valid;

    modport master (output kws_result, output kws_valid);
    modport slave  (input  kws_result, input  kws_valid);
endinterface

`default_nettype wire

// File: rtl/kws_uart_tx.sv
// ============================================================================
// Module      : kws_uart_tx
// Description : Byte UART transmitter with start/ready handshake; 8N1, or 8E1
//               when KWS_REPORT_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kws_uart_tx
    import kws_report_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       start,
    input  wire logic [7:0] data,
    output logic            ready,
    output logic            tx,
    output tx_phase_t       phase
);

    localparam int            CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST_CNT = CW'(CLK_DIV - 1);

    tx_phase_t     r_phase;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_bit_end;
`ifdef KWS_REPORT_PARITY_EN
    logic          r_par;
`endif

    assign w_bit_end = (r_cnt == C_LAST_CNT);
    // Ready in the last stop-bit cycle lets the next byte follow with no gap.
    assign ready     = (r_phase == TX_IDLE) || ((r_phase == TX_STOP) && w_bit_end);
    assign tx        = r_tx;
    assign phase     = r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef KWS_REPORT_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_cnt <= (w_bit_end || (r_phase == TX_IDLE)) ? '0 : r_cnt + 1'b1;
            if (start && ready) begin
                r_phase <= TX_START;
                r_shift <= data;
                r_bit   <= '0;
                r_tx    <= 1'b0;
`ifdef KWS_REPORT_PARITY_EN
                r_par   <= ^data;
`endif
            end else if (w_bit_end) begin
                case (r_phase)
                    TX_START: begin
                        r_phase <= TX_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                    TX_DATA: begin
                        if (r_bit == 3'd7) begin
`ifdef KWS_REPORT_PARITY_EN
                            r_phase <= TX_PARITY;
                            r_tx    <= r_par;
`else
                            r_phase <= TX_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
`ifdef KWS_REPORT_PARITY_EN
                    TX_PARITY: begin
                        r_phase <= TX_STOP;
                        r_tx    <= 1'b1;
                    end
`endif
                    default: begin
                        r_phase <= TX_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/kws_result_reporter.sv
// ============================================================================
// Module      : kws_result_reporter
// Description : Scans KWS detection vectors, suppresses repeats and reports
//               each winner as a 4-byte UART frame. KWS_REPORT_PARITY_EN
//               selects 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kws_result_reporter
    import kws_report_pkg::*;
#(
    parameter int NUM_KEYWORDS = 10,
    parameter int CLK_DIV      = 434,
    parameter int HOLDOFF      = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    kws_result_if.slave  res,
    output logic         tx,
    output logic         busy,
    output logic         report_done,
    output logic [7:0]   last_keyword,
    output logic [7:0]   dropped_cnt
);

    rpt_state_t              r_state;
    logic [NUM_KEYWORDS-1:0] r_vec;
    logic [7:0]              r_idx;
    logic                    r_found;
    logic [7:0]              r_kw;
    logic [7:0]              r_pop;
    logic [7:0]              r_holdoff;
    logic [7:0]              r_last;
    logic [7:0]              r_dropped;
    logic                    r_busy;
    logic                    r_done;
    logic [1:0]              r_byte;

    logic       w_xmit;
    logic       w_next_byte;
    logic       w_tx_start;
    logic [1:0] w_tx_sel;
    logic [7:0] w_tx_data;
    logic       w_tx_ready;
    tx_phase_t  w_tx_phase;

    assign w_xmit      = (r_state == ST_DECIDE) && r_found &&
                         !((r_kw == r_last) && (r_holdoff != 8'd0));
    assign w_next_byte = (r_state == ST_STOP) && w_tx_ready &&
                         (r_byte != 2'(FRAME_BYTES - 1));
    assign w_tx_start  = w_xmit || w_next_byte;
    assign w_tx_sel    = (r_state == ST_DECIDE) ? 2'd0 : r_byte + 2'd1;
    assign w_tx_data   = frame_byte(w_tx_sel, r_kw, r_pop);

    assign busy         = r_busy;
    assign report_done  = r_done;
    assign last_keyword = r_last;
    assign dropped_cnt  = r_dropped;

    kws_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_tx_start),
        .data  (w_tx_data),
        .ready (w_tx_ready),
        .tx    (tx),
        .phase (w_tx_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_vec     <= '0;
            r_idx     <= '0;
            r_found   <= 1'b0;
            r_kw      <= '0;
            r_pop     <= '0;
            r_holdoff <= '0;
            r_last    <= NO_KEYWORD;
            r_dropped <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_byte    <= '0;
        end else begin
            r_done <= 1'b0;
            if (res.kws_valid && (r_state != ST_IDLE) && (r_dropped != 8'hFF))
                r_dropped <= r_dropped + 8'd1;

            case (r_state)
                ST_IDLE: begin
                    if (res.kws_valid) begin
                        r_vec   <= res.kws_result;
                        r_idx   <= '0;
                        r_pop   <= '0;
                        r_found <= 1'b0;
                        r_kw    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Vector shifts down so bit 0 is always the one under test.
                    r_vec <= r_vec >> 1;
                    if (r_vec[0]) begin
                        r_pop <= r_pop + 8'd1;
                        if (!r_found) begin
                            r_found <= 1'b1;
                            r_kw    <= r_idx;
                        end
                    end
                    r_idx <= r_idx + 8'd1;
                    if (r_idx == 8'(NUM_KEYWORDS - 1))
                        r_state <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (w_xmit) begin
                        r_last    <= r_kw;
                        r_holdoff <= 8'(HOLDOFF);
                        r_byte    <= '0;
                        r_state   <= ST_START;
                    end else begin
                        if (r_holdoff != 8'd0)
                            r_holdoff <= r_holdoff - 8'd1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (w_tx_phase == TX_DATA)
                        r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_tx_phase == TX_STOP)
                        r_state <= ST_STOP;
                end
                ST_STOP: begin
                    if (w_tx_ready) begin
                        if (r_byte == 2'(FRAME_BYTES - 1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_byte  <= r_byte + 2'd1;
                            r_state <= ST_START;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/kws_result_reporter.md
Name: kws_result_reporter

Overview:
- Sits downstream of the keyword-spotting top and consumes its kws_result / kws_valid output pair.
- Scans each accepted detection vector for the winning keyword and applies repeat suppression (holdoff).
- Serialises each accepted detection to a host as a 4-byte UART 8N1 frame on a single tx pin.
- Provides the off-chip reporting end of the KWS result interface.

Parameters:
- NUM_KEYWORDS, 10: width of the detection vector; must be ≤ 255.
- CLK_DIV, 434: clk cycles per UART bit (50 MHz / 115200); must be ≥ 2.
- HOLDOFF, 4: number of subsequent scanned results during which a repeat of the same keyword is suppressed; must be ≤ 255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- kws_result  in  NUM_KEYWORDS  detection flags; bit i set means keyword i detected.
- kws_valid  in  1  one-cycle qualifier for kws_result.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high while a result is being scanned or transmitted.
- report_done  out  1  one-cycle pulse after the final stop bit of a frame.
- last_keyword  out  8  index of the most recently transmitted keyword; 8'hFF means none sent yet.
- dropped_cnt  out  8  count of kws_valid pulses ignored while busy; saturates at 255.

Behaviour:
- Reset values: tx=1, busy=0, report_done=0, last_keyword=8'hFF, dropped_cnt=0, holdoff_cnt=0, state=IDLE.
- Reset asserted at any time (including mid-frame): tx returns high immediately and all state clears.
- FSM states: IDLE, SCAN, DECIDE, START, DATA, STOP, DONE.
- IDLE:
  - kws_valid=1 → latch kws_result, clear scan index / popcount / found flag, go to SCAN; busy rises on the next edge.
- kws_valid while state≠IDLE: vector ignored; dropped_cnt += 1, saturating at 255.
- SCAN:
  - Examines one bit per cycle, index 0 up to NUM_KEYWORDS-1.
  - The first set bit found gives kw_idx; popcount accumulates every set bit.
  - Exactly NUM_KEYWORDS cycles, then DECIDE.
- DECIDE (1 cycle):
  - No bit set → no transmit; holdoff_cnt decrements (floor 0); go to IDLE.
  - kw_idx==last_keyword and holdoff_cnt≠0 → suppress; holdoff_cnt -= 1; go to IDLE.
  - Otherwise → load frame {8'hA5, kw_idx, popcount, XOR of the three}; last_keyword=kw_idx; holdoff_cnt=HOLDOFF; go to START.
- UART transmission:
  - Per byte: START (tx=0), DATA (8 bits, LSB first), STOP (tx=1).
  - Each bit is held exactly CLK_DIV cycles.
  - The 4 bytes are sent back-to-back with no idle gap.
  - Frame duration: 40*CLK_DIV cycles.
- DONE: report_done=1 for one cycle, busy=0, then IDLE; a kws_valid arriving in that DONE cycle is dropped.
- busy goes low in the DONE/IDLE-return cycle; when no transmit occurs, busy is low the cycle after DECIDE.
- Latency: first start-bit edge at kws_valid + 2 + NUM_KEYWORDS cycles.
- Widths: popcount is 8 bits; kw_idx is zero-extended to 8 bits.

Optional Feature:
- Macro KWS_REPORT_PARITY_EN.
- Defined: each byte gains an even-parity bit after bit 7 and before stop (8E1); frame duration becomes 44*CLK_DIV cycles.
- Undefined: 8N1 as above, with no parity logic present.

Decomposition:
- Shared package kws_report_pkg holds:
  - localparams FRAME_SYNC=8'hA5, FRAME_BYTES=4, NO_KEYWORD=8'hFF;
  - the FSM state enum encoding.
- One natural sub-module, kws_uart_tx: byte-level transmitter with a start/ready handshake, CLK_DIV bit counter and optional parity.
- The reporter FSM feeds bytes to kws_uart_tx.

Test Plan (CLK_DIV=4, HOLDOFF=2, NUM_KEYWORDS=10):
- kws_result=10'b0000001000 pulse → tx bytes A5,03,01,A7, 8N1 with 4-cycle bits; report_done pulses once; last_keyword=3.
- Same vector twice more → both suppressed (no tx activity); a fourth identical pulse → frame A5,03,01,A7 sent again.
- kws_result=10'b1000000101 → A5,00,03,A6; last_keyword=0.
- kws_result=0 → tx stays 1; busy high for 11 cycles, then low; no report_done.
- 300 kws_valid pulses during one frame → dropped_cnt=255, and the in-flight frame is unaffected.
- rst_n low during DATA of byte 2 → tx=1 and busy=0 immediately; last_keyword=FF after release; a new result is then reported normally.
